// File: rtl/alu_issue_queue_if.sv
// Handshake bundle for alu_issue_queue: request input, ALU drive/return, and result output.
interface alu_issue_queue_if #(
    parameter int unsigned TAG_W = 4
);
    // Request side
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    // ALU side
    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_overflow;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // The queue itself
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  alu_result, alu_zero, alu_overflow,
        input  out_ready,
        output in_ready,
        output alu_op, alu_a, alu_b,
        output out_valid, out_result, out_zero, out_overflow, out_illegal, out_tag
    );

    // Requester, ALU and consumer, seen together
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output alu_result, alu_zero, alu_overflow,
        output out_ready,
        input  in_ready,
        input  alu_op, alu_a, alu_b,
        input  out_valid, out_result, out_zero, out_overflow, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue: request FIFO -> registered ALU issue -> tag pipeline -> result FIFO.
// Issue is credit-gated so every in-flight op always has a free result FIFO slot.
module alu_issue_queue #(
    parameter int unsigned IN_DEPTH    = 4,
    parameter int unsigned OUT_DEPTH   = 4,
    parameter int unsigned ALU_LATENCY = 2,
    parameter int unsigned TAG_W       = 4
) (
    input logic           clk,
    input logic           rst,
    alu_issue_queue_if.slave bus
);
    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam logic [IN_AW:0]    IN_FULL      = (IN_AW + 1)'(IN_DEPTH);
    localparam logic [OUT_AW:0]   OUT_FULL     = (OUT_AW + 1)'(OUT_DEPTH);
    localparam logic [OUT_AW+1:0] CREDIT_LIMIT = (OUT_AW + 2)'(OUT_DEPTH);

    // Request FIFO
    logic [2:0]       r_in_op  [IN_DEPTH];
    logic [31:0]      r_in_a   [IN_DEPTH];
    logic [31:0]      r_in_b   [IN_DEPTH];
    logic [TAG_W-1:0] r_in_tag [IN_DEPTH];
    logic [IN_AW-1:0] r_in_wptr, r_in_rptr;
    logic [IN_AW:0]   r_in_count, w_in_count_d;
    logic             r_in_ready;

    // Issue registers and tag pipeline
    logic [2:0]             r_alu_op;
    logic [31:0]            r_alu_a, r_alu_b;
    logic [ALU_LATENCY-1:0] r_pipe_vld, r_pipe_ill;
    logic [TAG_W-1:0]       r_pipe_tag [ALU_LATENCY];
    logic [OUT_AW:0]        r_inflight, w_inflight_d;

    // Result FIFO
    logic [31:0]         r_out_result [OUT_DEPTH];
    logic [TAG_W-1:0]    r_out_tag    [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] r_out_zero, r_out_ovf, r_out_ill;
    logic [OUT_AW-1:0]   r_out_wptr, r_out_rptr;
    logic [OUT_AW:0]     r_out_count, w_out_count_d;

    logic w_push, w_issue, w_capture, w_pop, w_credit_ok, w_head_illegal, w_tail_ill;

    // Handshake decode, credit check and next-state counts
    always_comb begin
        w_push         = bus.in_valid && r_in_ready;
        // Results already waiting plus ops still in the ALU must leave room for one more
        w_credit_ok    = ({1'b0, r_out_count} + {1'b0, r_inflight}) < CREDIT_LIMIT;
        w_issue        = (r_in_count != '0) && w_credit_ok;
        w_head_illegal = (r_in_op[r_in_rptr][1:0] == 2'b11);
        w_capture      = r_pipe_vld[ALU_LATENCY-1];
        w_tail_ill     = r_pipe_ill[ALU_LATENCY-1];
        w_pop          = (r_out_count != '0) && bus.out_ready;
        w_in_count_d   = r_in_count + (IN_AW + 1)'(w_push) - (IN_AW + 1)'(w_issue);
        w_inflight_d   = r_inflight + (OUT_AW + 1)'(w_issue) - (OUT_AW + 1)'(w_capture);
        w_out_count_d  = r_out_count + (OUT_AW + 1)'(w_capture) - (OUT_AW + 1)'(w_pop);
    end

    // Request FIFO storage (contents are don't-care until counted valid)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_in_op[r_in_wptr]  <= bus.in_op;
            r_in_a[r_in_wptr]   <= bus.in_a;
            r_in_b[r_in_wptr]   <= bus.in_b;
            r_in_tag[r_in_wptr] <= bus.in_tag;
        end
    end

    // Request FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_count <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push)  r_in_wptr <= r_in_wptr + IN_AW'(1);
            if (w_issue) r_in_rptr <= r_in_rptr + IN_AW'(1);
            r_in_count <= w_in_count_d;
            r_in_ready <= (w_in_count_d != IN_FULL);
        end
    end

    // ALU operand registers; hold last values on a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op <= 3'b000;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_issue) begin
            r_alu_op <= r_in_op[r_in_rptr];
            r_alu_a  <= r_in_a[r_in_rptr];
            r_alu_b  <= r_in_b[r_in_rptr];
        end
    end

    // Tag pipeline matching ALU latency, plus in-flight credit count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_ill <= '0;
            for (int unsigned i = 0; i < ALU_LATENCY; i++) r_pipe_tag[i] <= '0;
            r_inflight <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_ill[0] <= w_issue && w_head_illegal;
            r_pipe_tag[0] <= r_in_tag[r_in_rptr];
            for (int unsigned i = 1; i < ALU_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_ill[i] <= r_pipe_ill[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            r_inflight <= w_inflight_d;
        end
    end

    // Result FIFO storage; illegal ops capture zeros instead of whatever the ALU produced
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_out_result[r_out_wptr] <= w_tail_ill ? 32'h0 : bus.alu_result;
            r_out_zero[r_out_wptr]   <= !w_tail_ill && bus.alu_zero;
            r_out_ovf[r_out_wptr]    <= !w_tail_ill && bus.alu_overflow;
            r_out_ill[r_out_wptr]    <= w_tail_ill;
            r_out_tag[r_out_wptr]    <= r_pipe_tag[ALU_LATENCY-1];
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_wptr  <= '0;
            r_out_rptr  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_capture) r_out_wptr <= r_out_wptr + OUT_AW'(1);
            if (w_pop)     r_out_rptr <= r_out_rptr + OUT_AW'(1);
            r_out_count <= w_out_count_d;
        end
    end

    // Drive interface outputs; result head is shown combinationally
    always_comb begin
        bus.in_ready     = r_in_ready;
        bus.alu_op       = r_alu_op;
        bus.alu_a        = r_alu_a;
        bus.alu_b        = r_alu_b;
        bus.out_valid    = (r_out_count != '0);
        bus.out_result   = r_out_result[r_out_rptr];
        bus.out_zero     = r_out_zero[r_out_rptr];
        bus.out_overflow = r_out_ovf[r_out_rptr];
        bus.out_illegal  = r_out_ill[r_out_rptr];
        bus.out_tag      = r_out_tag[r_out_rptr];
    end

    // The credit scheme must make a capture into a full, non-popping result FIFO impossible
    a_no_capture_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_capture && (r_out_count == OUT_FULL) && !w_pop));
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: behavioural 2-cycle ALU, scoreboard of expected results.
module tb_alu_issue_queue;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.TAG_W(TAG_W)) bus ();

    alu_issue_queue #(
        .IN_DEPTH    (4),
        .OUT_DEPTH   (4),
        .ALU_LATENCY (2),
        .TAG_W       (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {result, zero, overflow, illegal, tag}
    logic [38:0] sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU: {overflow, zero, result}; unassigned opcodes produce junk flags/result
    function automatic logic [33:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'h0;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b100: r = a ^ b;
            3'b101: r = (a < b) ? 32'h1 : 32'h0;
            3'b110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            default: begin r = 32'hDEAD_BEEF; v = 1'b1; end
        endcase
        return {v, (r == 32'h0), r};
    endfunction

    function automatic logic [38:0] expect_of(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [3:0] tag);
        logic [33:0] r;
        if (op[1:0] == 2'b11) return {32'h0, 1'b0, 1'b0, 1'b1, tag};
        r = alu_fn(op, a, b);
        return {r[31:0], r[32], r[33], 1'b0, tag};
    endfunction

    // ALU with one register stage: result for an op issued at edge N is valid before N+2
    always @(posedge clk) begin
        {bus.alu_overflow, bus.alu_zero, bus.alu_result} <= alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    // Scoreboard compare on every result handshake
    logic [38:0] mon_got;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.out_result, bus.out_zero, bus.out_overflow, bus.out_illegal, bus.out_tag};
            if (sb_q.size() == 0) check("sb_unexpected", 64'(sb_q.size()), 64'd1);
            else check("out_result", 64'(mon_got), 64'(sb_q.pop_front()));
        end
    end

    task automatic try_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input int max_cyc, output bit ok);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                sb_q.push_back(expect_of(op, a, b, tag));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bit ok;
        try_push(op, a, b, tag, 50, ok);
        if (!ok) check("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(negedge clk);
        check(tag, 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        check({tag, "_empty"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Wait for out_valid, then count how many of the next n cycles keep it high
    task automatic count_valid_run(input string tag, input int n);
        int hits;
        int c;
        hits = 0;
        c = 0;
        while (!bus.out_valid && c < 50) begin @(negedge clk); c++; end
        for (int k = 0; k < n; k++) begin
            if (bus.out_valid) hits++;
            @(negedge clk);
        end
        check(tag, 64'(hits), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int accepted;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single AND with latency check
        bus.out_ready = 1'b1;
        push(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
        @(negedge clk); check("lat_e0", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_e1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_e2", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_e3", 64'(bus.out_valid), 64'd1);
        wait_drain("and_drain");

        // Back-to-back ADDs, one result per cycle
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 8; i++) push(3'b010, 32'(i), 32'd1, 4'(i));
            count_valid_run("b2b_rate", 8);
        join
        wait_drain("b2b_drain");

        // Backpressure: only IN_DEPTH + OUT_DEPTH get in
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            try_push(3'b100, 32'h1000 + 32'(i), 32'h0F0F, 4'(i + 2), 8, ok);
            if (ok) accepted++;
        end
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        wait_drain("bp_drain");

        // Illegal opcode then SUB to zero
        @(posedge clk); #1;
        push(3'b111, 32'd5, 32'd5, 4'd7);
        push(3'b110, 32'd5, 32'd5, 4'd8);
        push(3'b011, 32'h7FFF_FFFF, 32'd1, 4'd1);
        push(3'b010, 32'h7FFF_FFFF, 32'd1, 4'd2);
        wait_drain("ill_drain");

        // Result FIFO full, then drain while captures land
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(3'b001, 32'h100 << i, 32'h3, 4'(i + 9));
        repeat (6) @(posedge clk);
        #1;
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        check("full_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        count_valid_run("full_drain_rate", 6);
        wait_drain("full_drain");

        // Reset mid-stream
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        push(3'b001, 32'h11, 32'h22, 4'd4);
        push(3'b001, 32'h33, 32'h44, 4'd5);
        push(3'b001, 32'h55, 32'h66, 4'd6);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_alu_op", 64'(bus.alu_op), 64'd1);
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("mid_rst_alu_b", 64'(bus.alu_b), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push(3'b010, 32'd100, 32'd23, 4'd9);
        wait_drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
